// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven phase sequencer for a two-road
// intersection with a pedestrian crossing. Green phases extend while their
// own road has demand and rest indefinitely when nothing conflicts; all
// timing is counted in external tick strobes. Road lamps are active-low,
// the walk lamp is active-high.
// Optional build macro NIGHT_FLASH_EN adds a `night` input and a FLASH state
// in which both yellow lamps blink on every tick.
// The current FSM state is always visible on `phase` for debug.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 25,
  parameter int YELLOW_T  = 3,
  parameter int CLEAR_T   = 2,
  parameter int WALK_T    = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req1,
  input  logic       req2,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_G1    = 3'd1,
    ST_Y1    = 3'd2,
    ST_G2    = 3'd3,
    ST_Y2    = 3'd4,
    ST_WALK  = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  // Durations widened by one bit so elapsed = cnt+1 never wraps.
  localparam logic [CNT_W:0]   MIN_E   = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   MAX_E   = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0]   YEL_E   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0]   CLR_E   = (CNT_W+1)'(CLEAR_T);
  localparam logic [CNT_W:0]   WALK_E  = (CNT_W+1)'(WALK_T);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(MAX_GREEN - 1);

  // Lamp vector order: {r1, y1, g1, r2, y2, g2, walk}
  localparam logic [6:0] LAMPS_RST = 7'b0110110;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             next_road2_q, next_road2_d; // 0: road 1 goes next, 1: road 2
  logic             ped_pend_q, ped_pend_d;
  logic [6:0]       lamps_q, lamps_d;
  logic [CNT_W:0]   elapsed;
  logic             other1, other2, in_green;
  logic             green_next_is_1;

`ifdef NIGHT_FLASH_EN
  logic             flash_lit_q, flash_lit_d; // 0 = yellows lit
`endif

  assign elapsed         = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign other1          = req2 | ped_pend_q;
  assign other2          = req1 | ped_pend_q;
  assign in_green        = (state_q == ST_G1) || (state_q == ST_G2);
  assign green_next_is_1 = !next_road2_q;

  // Next-state and next-road selection; transitions only happen on ticks.
  always_comb begin
    state_d      = state_q;
    next_road2_d = next_road2_q;
    if (tick) begin
      unique case (state_q)
        ST_CLR: begin
`ifdef NIGHT_FLASH_EN
          if (night) begin
            state_d = ST_FLASH;
          end else
`endif
          if (elapsed == CLR_E) begin
            if (ped_pend_q)           state_d = ST_WALK;
            else if (green_next_is_1) state_d = ST_G1;
            else                      state_d = ST_G2;
          end
        end
        ST_WALK: begin
          if (elapsed == WALK_E) state_d = green_next_is_1 ? ST_G1 : ST_G2;
        end
        ST_G1: begin
          if (other1 && ((elapsed >= MIN_E && !req1) || elapsed >= MAX_E))
            state_d = ST_Y1;
        end
        ST_G2: begin
          if (other2 && ((elapsed >= MIN_E && !req2) || elapsed >= MAX_E))
            state_d = ST_Y2;
        end
        ST_Y1: begin
          if (elapsed == YEL_E) begin
            state_d      = ST_CLR;
            next_road2_d = 1'b1;
          end
        end
        ST_Y2: begin
          if (elapsed == YEL_E) begin
            state_d      = ST_CLR;
            next_road2_d = 1'b0;
          end
        end
        ST_FLASH: begin
`ifdef NIGHT_FLASH_EN
          if (!night) state_d = ST_CLR;
`else
          state_d = ST_CLR;
`endif
        end
        default: state_d = ST_CLR;
      endcase
    end
  end

  // Phase counter: cleared on state change, counts ticks, saturates in green.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && state_q != ST_FLASH) begin
      if (in_green && cnt_q == SAT_CNT) cnt_d = cnt_q;
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  // Pedestrian latch: cleared on entering WALK, not re-armed while in WALK.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == ST_WALK && state_q != ST_WALK) ped_pend_d = 1'b0;
    else if (ped_req && state_q != ST_WALK)       ped_pend_d = 1'b1;
  end

`ifdef NIGHT_FLASH_EN
  // Yellow blink phase: lit on entry to FLASH, toggles on each tick inside it.
  always_comb begin
    flash_lit_d = flash_lit_q;
    if (state_d == ST_FLASH && state_q != ST_FLASH) flash_lit_d = 1'b0;
    else if (state_q == ST_FLASH && tick)           flash_lit_d = ~flash_lit_q;
  end
`endif

  // Lamp decode from the next state so lamps change with the state register.
  always_comb begin
    lamps_d = 7'b1111110;
    unique case (state_d)
      ST_G1:   lamps_d = 7'b1100110;
      ST_Y1:   lamps_d = 7'b1010110;
      ST_G2:   lamps_d = 7'b0111100;
      ST_Y2:   lamps_d = 7'b0111010;
      ST_WALK: lamps_d = 7'b0110111;
      ST_FLASH: begin
`ifdef NIGHT_FLASH_EN
        lamps_d = {1'b1, flash_lit_d, 1'b1, 1'b1, flash_lit_d, 1'b1, 1'b0};
`else
        lamps_d = LAMPS_RST;
`endif
      end
      default: lamps_d = LAMPS_RST;
    endcase
  end

  // State, counter, latches and registered lamp outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLR;
      cnt_q        <= '0;
      next_road2_q <= 1'b0;
      ped_pend_q   <= 1'b0;
      lamps_q      <= LAMPS_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      next_road2_q <= next_road2_d;
      ped_pend_q   <= ped_pend_d;
      lamps_q      <= lamps_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  // Blink phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flash_lit_q <= 1'b0;
    else      flash_lit_q <= flash_lit_d;
  end
`endif

  assign {r1, y1, g1, r2, y2, g2, walk} = lamps_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios with hand-computed
// durations, then randomized ticks/demands, all compared every cycle
// against a phase-level reference model.
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN = 5;
  localparam int MAX_GREEN = 25;
  localparam int YELLOW_T  = 3;
  localparam int CLEAR_T   = 2;
  localparam int WALK_T    = 8;

  // Lamp vectors {r1,y1,g1,r2,y2,g2,walk}
  localparam logic [6:0] L_ALLRED = 7'b0110110;
  localparam logic [6:0] L_G1     = 7'b1100110;
  localparam logic [6:0] L_WALK   = 7'b0110111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, req1 = 1'b0, req2 = 1'b0, ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic night = 1'b0;
`endif
  logic r1, y1, g1, r2, y2, g2, walk;
  logic [2:0] phase;
  logic [6:0] lamps;

  int checks = 0;
  int errors = 0;
  int dur;

  assign lamps = {r1, y1, g1, r2, y2, g2, walk};

  traffic_phase_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req1    (req1),
    .req2    (req2),
    .ped_req (ped_req),
`ifdef NIGHT_FLASH_EN
    .night   (night),
`endif
    .r1      (r1),
    .y1      (y1),
    .g1      (g1),
    .r2      (r2),
    .y2      (y2),
    .g2      (g2),
    .walk    (walk),
    .phase   (phase)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase numbers: 0 all-red, 1 G1, 2 Y1, 3 G2, 4 Y2, 5 walk.
  int m_ph, m_ticks, m_next, m_np;
  bit m_ped;

  function automatic int next_phase(int ph, int ticks, int nxt, bit ped,
                                    bit t, bit q1, bit q2);
    int el;
    int green;
    bit own, oth;
    el    = ticks + 1;
    green = (nxt == 1) ? 1 : 3;
    if (!t) return ph;
    case (ph)
      0: return (el == CLEAR_T) ? (ped ? 5 : green) : 0;
      5: return (el == WALK_T) ? green : 5;
      1, 3: begin
        own = (ph == 1) ? q1 : q2;
        oth = ((ph == 1) ? q2 : q1) | ped;
        if (oth && (el >= MAX_GREEN || (el >= MIN_GREEN && !own))) return ph + 1;
        return ph;
      end
      2, 4: return (el == YELLOW_T) ? 0 : ph;
      default: return ph;
    endcase
  endfunction

  function automatic logic [6:0] exp_lamps(int ph);
    logic [2:0] road1, road2; // {r,y,g}, active-low
    road1 = (ph == 1) ? 3'b110 : (ph == 2) ? 3'b101 : 3'b011;
    road2 = (ph == 3) ? 3'b110 : (ph == 4) ? 3'b101 : 3'b011;
    return {road1, road2, (ph == 5)};
  endfunction

  always_comb m_np = next_phase(m_ph, m_ticks, m_next, m_ped, tick, req1, req2);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph    <= 0;
      m_ticks <= 0;
      m_next  <= 1;
      m_ped   <= 1'b0;
    end else begin
      m_ph <= m_np;
      if (m_np != m_ph) m_ticks <= 0;
      else if (tick)    m_ticks <= m_ticks + 1;
      if (m_np == 0 && m_ph == 2) m_next <= 2;
      else if (m_np == 0 && m_ph == 4) m_next <= 1;
      if (m_np == 5 && m_ph != 5)     m_ped <= 1'b0;
      else if (ped_req && m_ph != 5)  m_ped <= 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    checks = checks + 1;
    if (phase !== 3'(m_ph) || lamps !== exp_lamps(m_ph)) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t phase=%0d lamps=%b expected phase=%0d lamps=%b",
               $time, phase, lamps, m_ph, exp_lamps(m_ph));
    end
  end

  // ---------------- driver / literal check tasks ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (phase !== 3'(p) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_phase", phase, p);
  endtask

  // Called at the first negedge inside phase p; returns cycles spent in it.
  task automatic measure(input int p, output int n);
    n = 0;
    while (phase === 3'(p) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_phase", phase, 0);
    chk("reset_lamps", lamps, L_ALLRED);

    // Startup: CLR for 2 ticks then G1, resting on req1 alone.
    rst = 1'b1; tick = 1'b1; req1 = 1'b1;
    measure(0, dur);
    chk("startup_clr_ticks", dur, CLEAR_T);
    chk("startup_phase_g1", phase, 1);
    chk("g1_lamps", lamps, L_G1);
    repeat (100) @(negedge clk);
    chk("g1_rest_100", phase, 1);

    // Demand on road 2 only: G1 leaves at once (min green long past).
    req1 = 1'b0; req2 = 1'b1;
    wait_phase(2);
    measure(2, dur);
    chk("y1_ticks", dur, YELLOW_T);
    measure(0, dur);
    chk("clr_after_y1", dur, CLEAR_T);
    chk("phase_g2", phase, 3);

    // Both roads demanding: greens run for exactly MAX_GREEN.
    req1 = 1'b1;
    measure(3, dur);
    chk("g2_max_green", dur, MAX_GREEN);
    measure(4, dur);
    chk("y2_ticks", dur, YELLOW_T);
    measure(0, dur);
    chk("clr_after_y2", dur, CLEAR_T);
    measure(1, dur);
    chk("g1_max_green", dur, MAX_GREEN);
    measure(2, dur);
    chk("y1_ticks_b", dur, YELLOW_T);
    req1 = 1'b0; req2 = 1'b0;
    measure(0, dur);
    chk("clr_to_g2", phase, 3);

    // Pedestrian press during resting G2.
    repeat (10) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_phase(4);
    measure(4, dur);
    chk("y2_ped_ticks", dur, YELLOW_T);
    measure(0, dur);
    chk("clr_ped_ticks", dur, CLEAR_T);
    chk("walk_phase", phase, 5);
    chk("walk_lamps", lamps, L_WALK);
    ped_req = 1'b1; // held through WALK: must not re-latch
    measure(5, dur);
    chk("walk_ticks", dur, WALK_T);
    ped_req = 1'b0;
    chk("after_walk_g1", phase, 1);
    repeat (50) @(negedge clk);
    chk("no_second_walk", phase, 1);

    // Asynchronous reset in the middle of Y1.
    req2 = 1'b1;
    wait_phase(2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_lamps", lamps, L_ALLRED);
    @(negedge clk);
    rst = 1'b1; req2 = 1'b0; req1 = 1'b1;
    measure(0, dur);
    chk("post_rst_clr", dur, CLEAR_T);
    chk("post_rst_g1", phase, 1);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      tick    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) req1 = ~req1;
      if ($urandom_range(0, 19) == 0) req2 = ~req2;
      ped_req = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 2000) == 0) rst = 1'b0;
      else                              rst = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
